// File: rtl/frame_protocol_checker.sv
// Hardware monitor for the start/wr/rd/stop frame protocol: grades each frame
// as pass/fail, records the last failure reason and keeps saturating counters.
module frame_protocol_checker #(
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wr,
  input  logic             rd,
  input  logic             stop,
  output logic             busy,
  output logic             frame_pass,
  output logic             frame_fail,
  output logic [2:0]       fail_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  localparam logic [1:0] RD_NONE  = 2'd0;
  localparam logic [1:0] RD_FIRST = 2'd1;
  localparam logic [1:0] RD_OK    = 2'd2;
  localparam logic [1:0] RD_BAD   = 2'd3;

  localparam logic [2:0] C_NO_WR   = 3'd1;
  localparam logic [2:0] C_RD_PAIR = 3'd2;
  localparam logic [2:0] C_NO_RD   = 3'd3;
  localparam logic [2:0] C_TIMEOUT = 3'd4;
  localparam logic [2:0] C_RESTART = 3'd5;

  localparam logic [15:0] MAX_T = 16'(MAX_CYCLES);

  function automatic logic [1:0] rd_step(input logic [1:0] cur, input logic r);
    logic [1:0] n;
    n = cur;
    if (cur == RD_NONE && r)  n = RD_FIRST;
    else if (cur == RD_FIRST) n = r ? RD_OK : RD_BAD;
    return n;
  endfunction

  // Zero means the frame is legal; otherwise the highest-priority reason.
  function automatic logic [2:0] grade(input logic w, input logic [1:0] rs);
    logic [2:0] c;
    if (rs == RD_BAD || rs == RD_FIRST) c = C_RD_PAIR;
    else if (rs == RD_NONE)             c = C_NO_RD;
    else if (!w)                        c = C_NO_WR;
    else                                c = 3'd0;
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  logic [0:0]  state, state_nxt;
  logic        start_q;
  logic        wr_seen, wr_nxt;
  logic [1:0]  rd_st, rds_nxt;
  logic [15:0] timer, tmr_nxt, tmr_inc;
  logic        rise;
  logic [1:0]  old_rs, new_rs;
  logic [2:0]  close_code, single_code;
  logic        dec_pass_p0, dec_fail_p0;
  logic [2:0]  dec_code_p0;

  assign rise        = start & ~start_q;
  assign old_rs      = rd_step(rd_st, rd);
  assign new_rs      = rd_step(RD_NONE, rd);
  assign close_code  = grade(wr_seen | wr, old_rs);
  assign single_code = grade(wr, new_rs);
  assign tmr_inc     = timer + 16'd1;
  assign busy        = (state == S_ACTIVE);

  // Decision stage: grade the current window cycle and choose the next frame context.
  always_comb begin
    state_nxt   = state;
    wr_nxt      = wr_seen;
    rds_nxt     = rd_st;
    tmr_nxt     = timer;
    dec_pass_p0 = 1'b0;
    dec_fail_p0 = 1'b0;
    dec_code_p0 = 3'd0;
    case (state)
      S_IDLE: begin
        if (rise && stop) begin
          dec_fail_p0 = 1'b1;
          dec_code_p0 = single_code;
        end else if (rise) begin
          state_nxt = S_ACTIVE;
          wr_nxt    = wr;
          rds_nxt   = new_rs;
          tmr_nxt   = 16'd1;
        end
      end
      default: begin
        if (stop) begin
          dec_pass_p0 = (close_code == 3'd0);
          dec_fail_p0 = (close_code != 3'd0);
          dec_code_p0 = close_code;
          state_nxt   = rise ? S_ACTIVE : S_IDLE;
        end else if (rise) begin
          dec_fail_p0 = 1'b1;
          dec_code_p0 = C_RESTART;
        end else if (tmr_inc == MAX_T) begin
          dec_fail_p0 = 1'b1;
          dec_code_p0 = C_TIMEOUT;
          state_nxt   = S_IDLE;
        end else begin
          wr_nxt  = wr_seen | wr;
          rds_nxt = old_rs;
          tmr_nxt = tmr_inc;
        end
        if (rise) begin
          wr_nxt  = wr;
          rds_nxt = new_rs;
          tmr_nxt = 16'd1;
        end
      end
    endcase
  end

  // Report stage: pulses, held fail code and counters one cycle after the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      wr_seen    <= 1'b0;
      rd_st      <= RD_NONE;
      timer      <= 16'd0;
      frame_pass <= 1'b0;
      frame_fail <= 1'b0;
      fail_code  <= 3'd0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      start_q    <= start;
      wr_seen    <= wr_nxt;
      rd_st      <= rds_nxt;
      timer      <= tmr_nxt;
      frame_pass <= dec_pass_p0;
      frame_fail <= dec_fail_p0;
      if (dec_fail_p0) fail_code <= dec_code_p0;
      if (dec_pass_p0) pass_cnt  <= sat_inc(pass_cnt);
      if (dec_fail_p0) fail_cnt  <= sat_inc(fail_cnt);
    end
  end

endmodule

// File: tb/tb_frame_protocol_checker.sv
// Directed bench for frame_protocol_checker: a default instance for grading and
// a MAX_CYCLES=8 / CNT_W=2 instance for timeout and saturation.
module tb_frame_protocol_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, wr = 1'b0, rd = 1'b0, stop = 1'b0;

  logic        busy, frame_pass, frame_fail;
  logic [2:0]  fail_code;
  logic [15:0] pass_cnt, fail_cnt;

  logic        busy2, frame_pass2, frame_fail2;
  logic [2:0]  fail_code2;
  logic [1:0]  pass_cnt2, fail_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_protocol_checker #(.MAX_CYCLES(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .rd(rd), .stop(stop),
    .busy(busy), .frame_pass(frame_pass), .frame_fail(frame_fail),
    .fail_code(fail_code), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  frame_protocol_checker #(.MAX_CYCLES(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .rd(rd), .stop(stop),
    .busy(busy2), .frame_pass(frame_pass2), .frame_fail(frame_fail2),
    .fail_code(fail_code2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
  );

  // One clock cycle of stimulus; outputs are observed 1 time unit after the edge.
  task automatic cyc(input logic s, input logic w, input logic r, input logic p);
    start = s; wr = w; rd = r; stop = p;
    @(posedge clk); #1;
  endtask

  // Frame with rise at index 0 and stop at index stop_at; returns right after the stop cycle.
  task automatic run_frame(input logic [31:0] wm, input logic [31:0] rm, input int stop_at);
    for (int i = 0; i <= stop_at; i++) cyc(i == 0, wm[i], rm[i], i == stop_at);
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if ({frame_pass, frame_fail} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {frame_pass, frame_fail}); end
    checks++; if (fail_code !== 3'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", fail_code); end
    checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_nominal;
    cyc(1, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy got=%0b exp=1", busy); end
    for (int i = 1; i <= 17; i++) cyc(0, i == 1, i == 2 || i == 3, i == 17);
    checks++; if (frame_pass !== 1'b1 || frame_fail !== 1'b0) begin errors++; $display("FAIL nominal_pulse got=%b exp=10", {frame_pass, frame_fail}); end
    checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin errors++; $display("FAIL nominal_cnt got=%0d/%0d exp=1/0", pass_cnt, fail_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_low got=%0b exp=0", busy); end
    cyc(0, 0, 0, 0);
    checks++; if (frame_pass !== 1'b0) begin errors++; $display("FAIL nominal_one_pulse got=%0b exp=0", frame_pass); end
  endtask

  task automatic test_single_rd;
    run_frame(32'h2, 32'h4, 10);
    checks++; if (frame_fail !== 1'b1 || fail_code !== 3'd2 || fail_cnt !== 16'd1) begin errors++; $display("FAIL single_rd got=%0b/%0d/%0d exp=1/2/1", frame_fail, fail_code, fail_cnt); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_missing;
    run_frame(32'h0, 32'hC, 6);
    checks++; if (frame_fail !== 1'b1 || fail_code !== 3'd1 || fail_cnt !== 16'd2) begin errors++; $display("FAIL no_wr got=%0b/%0d/%0d exp=1/1/2", frame_fail, fail_code, fail_cnt); end
    cyc(0, 0, 0, 0);
    run_frame(32'h2, 32'h0, 6);
    checks++; if (frame_fail !== 1'b1 || fail_code !== 3'd3 || fail_cnt !== 16'd3) begin errors++; $display("FAIL no_rd got=%0b/%0d/%0d exp=1/3/3", frame_fail, fail_code, fail_cnt); end
    cyc(0, 0, 0, 0);
    checks++; if (fail_code !== 3'd3 || frame_fail !== 1'b0) begin errors++; $display("FAIL code_hold got=%0d/%0b exp=3/0", fail_code, frame_fail); end
  endtask

  task automatic test_boundaries;
    run_frame(32'h2, 32'hC, 3);
    checks++; if (frame_pass !== 1'b1 || pass_cnt !== 16'd2) begin errors++; $display("FAIL rd_pair_at_stop got=%0b/%0d exp=1/2", frame_pass, pass_cnt); end
    cyc(0, 0, 0, 0);
    run_frame(32'h2, 32'h8, 3);
    checks++; if (frame_fail !== 1'b1 || fail_code !== 3'd2 || fail_cnt !== 16'd4) begin errors++; $display("FAIL first_rd_at_stop got=%0b/%0d/%0d exp=1/2/4", frame_fail, fail_code, fail_cnt); end
    cyc(0, 0, 0, 0);
    run_frame(32'h1, 32'h0, 0);
    checks++; if (frame_fail !== 1'b1 || fail_code !== 3'd3 || fail_cnt !== 16'd5 || busy !== 1'b0) begin errors++; $display("FAIL stop_in_rise got=%0b/%0d/%0d/%0b exp=1/3/5/0", frame_fail, fail_code, fail_cnt, busy); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_restart;
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, i == 1, i == 2 || i == 3, 0);
    cyc(1, 0, 0, 0);
    checks++; if (frame_fail !== 1'b1 || fail_code !== 3'd5 || busy !== 1'b1 || fail_cnt !== 16'd6) begin errors++; $display("FAIL restart got=%0b/%0d/%0b/%0d exp=1/5/1/6", frame_fail, fail_code, busy, fail_cnt); end
    for (int i = 6; i <= 12; i++) cyc(0, i == 6, i == 7 || i == 8, i == 12);
    checks++; if (frame_pass !== 1'b1 || pass_cnt !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL restart_second got=%0b/%0d/%0b exp=1/3/0", frame_pass, pass_cnt, busy); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_timeout;
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) cyc(0, i == 1, i == 2 || i == 3, 0);
    checks++; if (frame_fail2 !== 1'b0 || busy2 !== 1'b1) begin errors++; $display("FAIL timeout_early got=%0b/%0b exp=0/1", frame_fail2, busy2); end
    cyc(0, 0, 0, 0);
    checks++; if (frame_fail2 !== 1'b1 || fail_code2 !== 3'd4 || busy2 !== 1'b0) begin errors++; $display("FAIL timeout got=%0b/%0d/%0b exp=1/4/0", frame_fail2, fail_code2, busy2); end
    cyc(0, 0, 0, 0);
    run_frame(32'h2, 32'hC, 7);
    checks++; if (frame_pass2 !== 1'b1 || frame_fail2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL stop_at_limit got=%b/%0b exp=10/0", {frame_pass2, frame_fail2}, busy2); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_async_reset;
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, frame_pass, frame_fail, fail_code} !== 6'd0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin errors++; $display("FAIL async_reset got=%0b%0b%0b/%0d/%0d/%0d exp=000/0/0/0", busy, frame_pass, frame_fail, fail_code, pass_cnt, fail_cnt); end
    checks++; if (busy2 !== 1'b0 || pass_cnt2 !== 2'd0 || fail_code2 !== 3'd0) begin errors++; $display("FAIL async_reset2 got=%0b/%0d/%0d exp=0/0/0", busy2, pass_cnt2, fail_code2); end
    cyc(0, 1, 1, 1);
    rst_n = 1'b1;
    cyc(0, 0, 1, 1);
    checks++; if ({busy, frame_pass, frame_fail} !== 3'b000 || fail_cnt !== 16'd0) begin errors++; $display("FAIL post_reset_quiet got=%b/%0d exp=000/0", {busy, frame_pass, frame_fail}, fail_cnt); end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 4; k++) begin
      run_frame(32'h1, 32'h6, 4);
      cyc(0, 0, 0, 0);
    end
    checks++; if (pass_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_pass_cnt got=%0d exp=3", pass_cnt2); end
    checks++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0) begin errors++; $display("FAIL wide_pass_cnt got=%0d/%0d exp=4/0", pass_cnt, fail_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_single_rd();
    test_missing();
    test_boundaries();
    test_restart();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_protocol_checker.md
Name: frame_protocol_checker

Overview:
- Synthesizable RTL receiver/checker for the start/wr/rd/stop frame protocol that the verification benches currently check only with SVA.
- Each frame opens on a rising start and closes on the first stop; inside that window it must contain at least one wr and one rd followed immediately by a second rd.
- The block samples the four control lines, grades each frame as pass or fail, and reports a fail code plus saturating statistics counters.
- It sits beside any protocol initiator as an always-on hardware monitor.

Parameters:
- MAX_CYCLES, 64, frame timeout in cycles; the rise cycle counts as cycle 1; legal range 2..65535.
- CNT_W, 16, width of the pass and fail counters.

Ports:
- clk  input  1  system clock; all sampling on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame open; only its rising edge is significant.
- wr  input  1  write strobe.
- rd  input  1  read strobe.
- stop  input  1  frame close; first high cycle inside a frame ends the frame.
- busy  output  1  high while a frame is open (ACTIVE state).
- frame_pass  output  1  one-cycle pulse, frame legal.
- frame_fail  output  1  one-cycle pulse, frame illegal.
- fail_code  output  3  reason for the last failure; held until the next failure.
- pass_cnt  output  CNT_W  number of passed frames; saturates at all-ones.
- fail_cnt  output  CNT_W  number of failed frames; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, start_q=0, all outputs 0, internal flags and timer cleared. Reset mid-frame abandons the frame with no report.
- Edge detect: rise = start & ~start_q, where start_q is start registered each cycle.
- FSM states:
  - IDLE -> ACTIVE on rise.
  - ACTIVE -> IDLE on stop or on timeout.
  - ACTIVE -> ACTIVE on rise (restart; see below).
- The rise cycle is part of the window. wr, rd and stop sampled in that same cycle are evaluated.
- wr_seen is set on any wr=1 cycle in the window, including the stop cycle.
- rd tracker, states NONE/FIRST/OK/BAD:
  - NONE -> FIRST on rd=1.
  - FIRST -> OK if rd=1 in the next cycle, else FIRST -> BAD.
  - OK and BAD are sticky until the frame ends.
  - Later rd pulses are ignored.
- Stop-cycle rd evaluation: if the tracker is FIRST and rd=1 in the stop cycle, the pair counts as OK. If the first rd occurs in the stop cycle itself, the pair is incomplete and reports code 2.
- Stop in the rise cycle: the window is that single cycle, so the frame fails (code 2 or 3).
- Frame close on stop: pass if wr_seen and rd state OK; otherwise fail with the highest-priority code:
  - 2 RD_NOT_PAIRED (BAD or incomplete)
  - 3 NO_RD
  - 1 NO_WR
- Timeout: a timer counts window cycles. If it reaches MAX_CYCLES with no stop, the frame fails with code 4 TIMEOUT and the FSM returns to IDLE. If stop arrives in the MAX_CYCLES-th cycle, stop wins.
- Restart: a rise while ACTIVE, with no stop in that cycle, fails the old frame with code 5 RESTART. A new frame opens in that same cycle with flags reset and that cycle's wr/rd evaluated for the new frame. If stop and rise occur in the same cycle, the old frame closes normally and a new frame opens.
- Latency: frame_pass/frame_fail, fail_code and the counter increment all register 1 cycle after the deciding cycle. At most one pulse per cycle; a pulse never coincides with another pulse.
- stop outside a frame, and wr/rd while IDLE, are ignored.
- fail_code 0 means no failure since reset.
- busy = (state == ACTIVE), registered.

Test Plan:
- Nominal frame: rise at cycle 0, wr at cycle 1, rd at cycles 2-3, stop at cycle 17 -> frame_pass pulse at cycle 18, pass_cnt=1, fail_cnt=0, busy low from cycle 18.
- Single rd: rise at 0, wr at 1, rd only at cycle 2, stop at 10 -> frame_fail at 11, fail_code=2, fail_cnt=1.
- Missing wr and missing rd: rise at 0, rd at 2-3, stop at 6 -> fail_code=1. Then a second frame with wr only -> fail_code=3, fail_cnt=2.
- Boundaries: second rd coincides with stop -> pass. First rd coincides with stop -> fail code 2. Stop in the rise cycle -> fail code 3.
- Timeout with MAX_CYCLES=8: rise at 0, wr at 1, rd at 2-3, no stop -> frame_fail at cycle 8, fail_code=4, busy=0. A stop at cycle 7 instead -> pass.
- Restart, reset and saturation:
  - start toggled to rise at 0 and again at 5, stop at 12 -> fail code 5 at cycle 6; the second frame is graded on its own wr/rd.
  - rst_n pulsed low mid-frame -> all outputs 0 immediately (asynchronous), with no pulse.
  - With CNT_W=2, four passes -> pass_cnt holds at 3.
